// File: rtl/our_eth_pkg.sv
// rtl/our_eth_pkg.sv - shared constants and FSM encoding for the receive header parser
//
// Purpose:
//   Header geometry, default type codes and the parser state encoding. Imported by
//   our_type_match and our_header_parser.
//
// Contents:
//   HDR_BYTES, TYPE_W        header length in bytes, width of the type word
//   TYPE_OFS/SEQ_OFS/LEN_OFS byte offsets of the type, sequence and length fields
//   TYPE_*                   default recognised type codes
//   parse_state_e            parser FSM states
package our_eth_pkg;

  localparam int HDR_BYTES = 8;
  localparam int TYPE_W    = 32;

  localparam int TYPE_OFS  = 0;
  localparam int SEQ_OFS   = 4;
  localparam int LEN_OFS   = 6;

  localparam logic [TYPE_W-1:0] TYPE_ONE   = 32'h0000_0000;
  localparam logic [TYPE_W-1:0] TYPE_TWO   = 32'h0000_0001;
  localparam logic [TYPE_W-1:0] TYPE_TWO_2 = 32'h0000_0002;
  localparam logic [TYPE_W-1:0] TYPE_START = 32'h0000_0030;
  localparam logic [TYPE_W-1:0] TYPE_STOP  = 32'h0000_0031;
  localparam logic [TYPE_W-1:0] TYPE_SYNC  = 32'h0000_00C0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_DROP = 2'd3
  } parse_state_e;

endpackage

// File: rtl/our_type_match.sv
// rtl/our_type_match.sv - masked priority compare of a type word against a code table
//
// Purpose:
//   Purely combinational. Compares word_i against each TYPE_CODES entry using only the
//   bits set in TYPE_MASK. The lowest matching entry index wins, so hit_o is one-hot
//   or zero. The parent registers both outputs.
//
// Ports:
//   word_i  in   TYPE_W    type word, first received byte in the MSBs
//   hit_o   out  N_TYPES   one-hot index of the lowest matching entry, 0 on miss
//   miss_o  out  1         no entry matched
module our_type_match
  import our_eth_pkg::*;
#(
  parameter int                        N_TYPES    = 6,
  parameter logic [N_TYPES*TYPE_W-1:0] TYPE_CODES = {TYPE_SYNC, TYPE_STOP, TYPE_START,
                                                     TYPE_TWO_2, TYPE_TWO, TYPE_ONE},
  parameter logic [TYPE_W-1:0]         TYPE_MASK  = 32'h0000_00FF
) (
  input  logic [TYPE_W-1:0]  word_i,
  output logic [N_TYPES-1:0] hit_o,
  output logic               miss_o
);

  // Scan from the top entry down so the last assignment, i.e. the lowest
  // matching index, is the one that survives.
  always_comb begin
    hit_o  = '0;
    miss_o = 1'b1;
    for (int i = N_TYPES - 1; i >= 0; i--) begin
      if (((word_i ^ TYPE_CODES[i*TYPE_W +: TYPE_W]) & TYPE_MASK) == '0) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
        miss_o   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/our_header_parser.sv
// rtl/our_header_parser.sv - receive frame header parser with type classification and payload framing
//
// Purpose:
//   Consumes the bytes of a frame already addressed to us (qualified by ena), parses the
//   8-byte header (type, sequence, length), classifies the type word against a code
//   table and forwards the payload with framing and runt/length error strobes.
//
// Ports:
//   clock         in   1        system clock
//   aclr_n        in   1        asynchronous active-low reset
//   sclr          in   1        synchronous clear, same effect as reset
//   ena           in   1        frame qualifier; low for one or more cycles is a gap
//   datain        in   8        frame byte, valid while ena=1
//   type_hit      out  N_TYPES  one-hot type classification, held for the rest of the frame
//   unknown_type  out  1        type matched no entry, held for the rest of the frame
//   hdr_done      out  1        strobe: seq_num/pay_len just updated
//   seq_num       out  16       header bytes 4..5, big-endian
//   pay_len       out  16       header bytes 6..7, big-endian
//   pay_data      out  8        payload byte
//   pay_valid     out  1        pay_data valid
//   pay_last      out  1        final payload byte
//   hdr_err       out  1        strobe: frame ended inside the header (runt)
//   len_err       out  1        strobe: length too large, frame truncated, or overrun
module our_header_parser
  import our_eth_pkg::*;
#(
  parameter int                        N_TYPES    = 6,
  parameter logic [N_TYPES*TYPE_W-1:0] TYPE_CODES = {TYPE_SYNC, TYPE_STOP, TYPE_START,
                                                     TYPE_TWO_2, TYPE_TWO, TYPE_ONE},
  parameter logic [TYPE_W-1:0]         TYPE_MASK  = 32'h0000_00FF,
  parameter logic [15:0]               MAX_PAY    = 16'd1472
) (
  input  logic               clock,
  input  logic               aclr_n,
  input  logic               sclr,
  input  logic               ena,
  input  logic [7:0]         datain,
  output logic [N_TYPES-1:0] type_hit,
  output logic               unknown_type,
  output logic               hdr_done,
  output logic [15:0]        seq_num,
  output logic [15:0]        pay_len,
  output logic [7:0]         pay_data,
  output logic               pay_valid,
  output logic               pay_last,
  output logic               hdr_err,
  output logic               len_err
);

  // Byte index of the last type byte and of the last header byte.
  localparam logic [2:0] TYPE_LAST_IDX = 3'(TYPE_OFS + TYPE_W / 8 - 1);
  localparam logic [2:0] HDR_LAST_IDX  = 3'(HDR_BYTES - 1);
  // While the last header byte is on datain, the shift register holds bytes
  // SEQ_OFS..LEN_OFS, so the sequence field sits one byte above the bottom.
  localparam int         SEQ_LSB       = 8 * (LEN_OFS - SEQ_OFS - 1);

  parse_state_e        state_q;
  logic [2:0]          byte_idx_q;
  logic [23:0]         hdr_sr_q;
  logic [15:0]         pay_cnt_q;
  logic                err_seen_q;

  logic [N_TYPES-1:0]  type_hit_q;
  logic                unknown_q;
  logic                hdr_done_q;
  logic [15:0]         seq_q;
  logic [15:0]         len_q;
  logic [7:0]          pay_data_q;
  logic                pay_valid_q;
  logic                pay_last_q;
  logic                hdr_err_q;
  logic                len_err_q;

  logic [TYPE_W-1:0]   type_word_d;
  logic [15:0]         len_word_d;
  logic                len_big_d;
  logic                len_ok_d;
  logic [N_TYPES-1:0]  match_hit;
  logic                match_miss;

  // The incoming byte completes the word on the cycle it arrives, so these
  // are only meaningful on the last type byte and the last header byte.
  assign type_word_d = {hdr_sr_q, datain};
  assign len_word_d  = {hdr_sr_q[7:0], datain};
  assign len_big_d   = (len_word_d > MAX_PAY);
  assign len_ok_d    = (len_word_d != 16'd0) && !len_big_d;

  our_type_match #(
    .N_TYPES    (N_TYPES),
    .TYPE_CODES (TYPE_CODES),
    .TYPE_MASK  (TYPE_MASK)
  ) u_match (
    .word_i (type_word_d),
    .hit_o  (match_hit),
    .miss_o (match_miss)
  );

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= '0;
      hdr_sr_q    <= '0;
      pay_cnt_q   <= '0;
      err_seen_q  <= 1'b0;
      type_hit_q  <= '0;
      unknown_q   <= 1'b0;
      hdr_done_q  <= 1'b0;
      seq_q       <= '0;
      len_q       <= '0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_last_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else if (sclr) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= '0;
      hdr_sr_q    <= '0;
      pay_cnt_q   <= '0;
      err_seen_q  <= 1'b0;
      type_hit_q  <= '0;
      unknown_q   <= 1'b0;
      hdr_done_q  <= 1'b0;
      seq_q       <= '0;
      len_q       <= '0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_last_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      // Strobes default low every cycle.
      hdr_done_q  <= 1'b0;
      pay_valid_q <= 1'b0;
      pay_last_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      len_err_q   <= 1'b0;

      if (!ena) begin
        // Gap: the frame is over whatever state we were in. The held type
        // outputs drop here; seq_num/pay_len stay until the next header.
        type_hit_q <= '0;
        unknown_q  <= 1'b0;
        byte_idx_q <= '0;
        err_seen_q <= 1'b0;
        if (state_q == ST_HDR) hdr_err_q <= 1'b1;
        // PAY is left as soon as the count reaches zero, so being here
        // means bytes were still owed.
        if (state_q == ST_PAY) len_err_q <= 1'b1;
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            hdr_sr_q   <= {hdr_sr_q[15:0], datain};
            byte_idx_q <= 3'd1;
            state_q    <= ST_HDR;
          end

          ST_HDR: begin
            hdr_sr_q   <= {hdr_sr_q[15:0], datain};
            byte_idx_q <= byte_idx_q + 3'd1;
            if (byte_idx_q == TYPE_LAST_IDX) begin
              type_hit_q <= match_hit;
              unknown_q  <= match_miss;
            end
            if (byte_idx_q == HDR_LAST_IDX) begin
              hdr_done_q <= 1'b1;
              seq_q      <= hdr_sr_q[SEQ_LSB +: 16];
              len_q      <= len_word_d;
              pay_cnt_q  <= len_word_d;
              if (len_ok_d) begin
                state_q <= ST_PAY;
              end else begin
                state_q <= ST_DROP;
                // An oversize length is the frame's one error; trailing
                // bytes must not raise a second overrun strobe.
                if (len_big_d) begin
                  len_err_q  <= 1'b1;
                  err_seen_q <= 1'b1;
                end
              end
            end
          end

          ST_PAY: begin
            pay_data_q  <= datain;
            pay_valid_q <= 1'b1;
            pay_cnt_q   <= pay_cnt_q - 16'd1;
            if (pay_cnt_q == 16'd1) begin
              pay_last_q <= 1'b1;
              state_q    <= ST_DROP;
            end
          end

          ST_DROP: begin
            // Overrun: flag the first surplus byte only.
            if (!err_seen_q) begin
              len_err_q  <= 1'b1;
              err_seen_q <= 1'b1;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign type_hit     = type_hit_q;
  assign unknown_type = unknown_q;
  assign hdr_done     = hdr_done_q;
  assign seq_num      = seq_q;
  assign pay_len      = len_q;
  assign pay_data     = pay_data_q;
  assign pay_valid    = pay_valid_q;
  assign pay_last     = pay_last_q;
  assign hdr_err      = hdr_err_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_our_header_parser.sv
// tb/tb_our_header_parser.sv - self-checking bench for our_header_parser
module tb_our_header_parser;

  logic        clk;
  logic        aclr_n;
  logic        sclr;
  logic        ena;
  logic [7:0]  datain;

  logic [5:0]  type_hit;
  logic        unknown_type;
  logic        hdr_done;
  logic [15:0] seq_num;
  logic [15:0] pay_len;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        hdr_err;
  logic        len_err;

  logic [1:0]  type_hit2;
  logic        unknown_type2;
  logic        hdr_done2;
  logic [15:0] seq_num2;
  logic [15:0] pay_len2;
  logic [7:0]  pay_data2;
  logic        pay_valid2;
  logic        pay_last2;
  logic        hdr_err2;
  logic        len_err2;

  int total;
  int bad;
  int frame_no;

  logic [7:0]  fr[$];
  logic [31:0] codes1 [6];
  logic [31:0] codes2 [2];
  logic [15:0] cur_seq;
  logic [15:0] cur_len;

  our_header_parser dut (
    .clock        (clk),
    .aclr_n       (aclr_n),
    .sclr         (sclr),
    .ena          (ena),
    .datain       (datain),
    .type_hit     (type_hit),
    .unknown_type (unknown_type),
    .hdr_done     (hdr_done),
    .seq_num      (seq_num),
    .pay_len      (pay_len),
    .pay_data     (pay_data),
    .pay_valid    (pay_valid),
    .pay_last     (pay_last),
    .hdr_err      (hdr_err),
    .len_err      (len_err)
  );

  our_header_parser #(
    .N_TYPES    (2),
    .TYPE_CODES ({32'hABCD_0001, 32'h0000_00C0}),
    .TYPE_MASK  (32'hFFFF_FFFF),
    .MAX_PAY    (16'd1472)
  ) dut2 (
    .clock        (clk),
    .aclr_n       (aclr_n),
    .sclr         (sclr),
    .ena          (ena),
    .datain       (datain),
    .type_hit     (type_hit2),
    .unknown_type (unknown_type2),
    .hdr_done     (hdr_done2),
    .seq_num      (seq_num2),
    .pay_len      (pay_len2),
    .pay_data     (pay_data2),
    .pay_valid    (pay_valid2),
    .pay_last     (pay_last2),
    .hdr_err      (hdr_err2),
    .len_err      (len_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s frame=%0d observed=%0h expected=%0h", tag, frame_no, obs, exp);
    end
  endtask

  // Reference classification: lowest table entry equal under the mask.
  function automatic logic [6:0] classify1(input logic [31:0] w);
    for (int i = 0; i < 6; i++)
      if ((w & 32'h0000_00FF) == (codes1[i] & 32'h0000_00FF)) return {1'b0, 6'(1 << i)};
    return 7'b100_0000;
  endfunction

  function automatic logic [2:0] classify2(input logic [31:0] w);
    for (int i = 0; i < 2; i++)
      if (w == codes2[i]) return {1'b0, 2'(1 << i)};
    return 3'b100;
  endfunction

  task automatic build(input logic [31:0] ty, input logic [15:0] seq, input logic [15:0] len);
    fr.delete();
    fr.push_back(ty[31:24]);
    fr.push_back(ty[23:16]);
    fr.push_back(ty[15:8]);
    fr.push_back(ty[7:0]);
    fr.push_back(seq[15:8]);
    fr.push_back(seq[7:0]);
    fr.push_back(len[15:8]);
    fr.push_back(len[7:0]);
  endtask

  task automatic add_pay(input int cnt);
    for (int i = 0; i < cnt; i++) fr.push_back(8'($urandom));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".type_hit"},  32'(type_hit),     32'd0);
    chk({tag, ".unknown"},   32'(unknown_type), 32'd0);
    chk({tag, ".hdr_done"},  32'(hdr_done),     32'd0);
    chk({tag, ".seq_num"},   32'(seq_num),      32'd0);
    chk({tag, ".pay_len"},   32'(pay_len),      32'd0);
    chk({tag, ".pay_data"},  32'(pay_data),     32'd0);
    chk({tag, ".pay_valid"}, 32'(pay_valid),    32'd0);
    chk({tag, ".pay_last"},  32'(pay_last),     32'd0);
    chk({tag, ".hdr_err"},   32'(hdr_err),      32'd0);
    chk({tag, ".len_err"},   32'(len_err),      32'd0);
  endtask

  // Expected outputs after input cycle r of an n-byte frame (r >= n: gap cycles),
  // derived from the frame contents alone.
  task automatic check_cycle(input int n, input int r);
    logic [31:0] w;
    logic [6:0]  c1;
    logic [2:0]  c2;
    int          len;
    int          emit;
    bit          legal, hd, pv, pl, le, he;
    c1 = '0;
    c2 = '0;
    len = 0;
    if (n >= 4 && r >= 3 && r < n) begin
      w  = {fr[0], fr[1], fr[2], fr[3]};
      c1 = classify1(w);
      c2 = classify2(w);
    end
    if (n >= 8) len = int'({fr[6], fr[7]});
    hd = (n >= 8) && (r == 7);
    if (hd) begin
      cur_seq = {fr[4], fr[5]};
      cur_len = 16'(len);
    end
    legal = (n >= 8) && (len >= 1) && (len <= 1472);
    emit  = 0;
    if (legal) emit = (len < n - 8) ? len : n - 8;
    pv = legal && (r >= 8) && (r < 8 + emit);
    pl = legal && (n >= 8 + len) && (r == 8 + len - 1);
    le = 1'b0;
    if (n >= 8) begin
      if (len > 1472) le = (r == 7);
      else if (legal) begin
        if (n < 8 + len)      le = (r == n);
        else if (n > 8 + len) le = (r == 8 + len);
      end
    end
    he = (n < 8) && (r == n);

    chk("type_hit",  32'(type_hit),     32'(c1[5:0]));
    chk("unknown",   32'(unknown_type), 32'(c1[6]));
    chk("hdr_done",  32'(hdr_done),     32'(hd));
    chk("seq_num",   32'(seq_num),      32'(cur_seq));
    chk("pay_len",   32'(pay_len),      32'(cur_len));
    chk("pay_valid", 32'(pay_valid),    32'(pv));
    chk("pay_last",  32'(pay_last),     32'(pl));
    chk("len_err",   32'(len_err),      32'(le));
    chk("hdr_err",   32'(hdr_err),      32'(he));
    if (pv) chk("pay_data", 32'(pay_data), 32'(fr[r]));

    chk("x2.type_hit",  32'(type_hit2),     32'(c2[1:0]));
    chk("x2.unknown",   32'(unknown_type2), 32'(c2[2]));
    chk("x2.hdr_done",  32'(hdr_done2),     32'(hd));
    chk("x2.seq_num",   32'(seq_num2),      32'(cur_seq));
    chk("x2.pay_len",   32'(pay_len2),      32'(cur_len));
    chk("x2.pay_valid", 32'(pay_valid2),    32'(pv));
    chk("x2.pay_last",  32'(pay_last2),     32'(pl));
    chk("x2.len_err",   32'(len_err2),      32'(le));
    chk("x2.hdr_err",   32'(hdr_err2),      32'(he));
    if (pv) chk("x2.pay_data", 32'(pay_data2), 32'(fr[r]));
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic run_frame(input int gap);
    int n;
    n = fr.size();
    for (int r = 0; r < n; r++) begin
      ena    = 1'b1;
      datain = fr[r];
      @(negedge clk);
      check_cycle(n, r);
    end
    for (int g = 0; g < gap; g++) begin
      ena    = 1'b0;
      datain = 8'($urandom);
      @(negedge clk);
      check_cycle(n, n + g);
    end
    frame_no++;
  endtask

  initial begin
    logic [31:0] ty;
    logic [15:0] ln;
    int          sel, mode, n, np;

    total    = 0;
    bad      = 0;
    frame_no = 0;
    cur_seq  = '0;
    cur_len  = '0;
    codes1   = '{32'h00, 32'h01, 32'h02, 32'h30, 32'h31, 32'hC0};
    codes2   = '{32'h0000_00C0, 32'hABCD_0001};

    aclr_n = 1'b0;
    sclr   = 1'b0;
    ena    = 1'b0;
    datain = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset");
    aclr_n = 1'b1;
    @(negedge clk);
    check_zero("reset_idle");

    // Basic frame: type 1, seq 5, len 3, payload AA BB CC.
    build(32'h0000_0001, 16'h0005, 16'h0003);
    fr.push_back(8'hAA);
    fr.push_back(8'hBB);
    fr.push_back(8'hCC);
    run_frame(1);

    // SYNC type, then an unknown type in the following frame.
    build(32'h0000_00C0, 16'h0001, 16'h0002);
    add_pay(2);
    run_frame(1);
    build(32'h0000_0099, 16'h0002, 16'h0001);
    add_pay(1);
    run_frame(1);

    // Runt: five bytes only, type already classified.
    build(32'h0000_0030, 16'h1234, 16'h0004);
    while (fr.size() > 5) void'(fr.pop_back());
    run_frame(2);

    // Overrun, truncation, oversize length, zero length.
    build(32'h0000_0031, 16'h0100, 16'h0003);
    add_pay(5);
    run_frame(1);
    build(32'h0000_0002, 16'h0101, 16'h0004);
    add_pay(2);
    run_frame(1);
    build(32'h0000_0001, 16'h0102, 16'hFFFF);
    add_pay(2);
    run_frame(1);
    build(32'h0000_0000, 16'h0103, 16'h0000);
    run_frame(1);

    // Length boundaries around the maximum payload.
    build(32'hABCD_0001, 16'h0200, 16'd1472);
    add_pay(1473);
    run_frame(1);
    build(32'h0000_00C0, 16'h0201, 16'd1473);
    run_frame(1);

    // Asynchronous reset in the middle of the payload.
    build(32'h0000_0001, 16'h0300, 16'd10);
    add_pay(10);
    for (int r = 0; r < 12; r++) begin
      ena    = 1'b1;
      datain = fr[r];
      @(negedge clk);
      check_cycle(fr.size(), r);
    end
    #2 aclr_n = 1'b0;
    #1 check_zero("aclr_mid");
    cur_seq = '0;
    cur_len = '0;
    @(negedge clk);
    ena    = 1'b0;
    aclr_n = 1'b1;
    @(negedge clk);
    check_zero("aclr_release");
    frame_no++;
    build(32'h0000_0002, 16'h0301, 16'h0002);
    add_pay(2);
    run_frame(1);

    // Synchronous clear after the type has been classified.
    build(32'h0000_0030, 16'h0400, 16'h0005);
    add_pay(5);
    for (int r = 0; r < 5; r++) begin
      ena    = 1'b1;
      datain = fr[r];
      @(negedge clk);
      check_cycle(fr.size(), r);
    end
    sclr   = 1'b1;
    datain = fr[5];
    @(negedge clk);
    cur_seq = '0;
    cur_len = '0;
    check_zero("sclr");
    sclr = 1'b0;
    ena  = 1'b0;
    @(negedge clk);
    check_zero("sclr_gap");
    frame_no++;

    // Randomised frames with short gaps.
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 8);
      if (sel < 6)       ty = {24'($urandom), codes1[sel][7:0]};
      else if (sel == 6) ty = 32'hABCD_0001;
      else if (sel == 7) ty = 32'h0000_00C0;
      else               ty = $urandom;
      ln   = 16'($urandom_range(1, 12));
      mode = $urandom_range(0, 5);
      build(ty, 16'($urandom), ln);
      if (mode == 0) begin
        n = $urandom_range(1, 7);
        while (fr.size() > n) void'(fr.pop_back());
      end else begin
        if (mode == 1)      np = $urandom_range(0, int'(ln) - 1);
        else if (mode == 2) np = int'(ln) + $urandom_range(1, 3);
        else                np = int'(ln);
        add_pay(np);
      end
      run_frame($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
